// File: rtl/i3c_bus_frontend.sv
// SCL/SDA pad front end: synchroniser, glitch filter, edge/START/STOP, bus-free, arbitration, OD/PP drive.
// Latency: pad->ctrl_*_o SyncStages+filt_cycles_i+1 cycles, event pulses one cycle later; ctrl->pad 1 cycle.
// Backpressure: none; pad-facing block samples and drives every cycle with no flow control.
module i3c_bus_frontend #(
  parameter int SyncStages = 2,
  parameter int FiltW      = 4,
  parameter int IdleW      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             scl_o,
  output logic             scl_en_o,
  output logic             sda_o,
  output logic             sda_en_o,
  input  logic             ctrl_scl_i,
  input  logic             ctrl_sda_i,
  input  logic             scl_pp_en_i,
  input  logic             sda_pp_en_i,
  input  logic [FiltW-1:0] filt_cycles_i,
  input  logic [IdleW-1:0] idle_cycles_i,
  output logic             ctrl_scl_o,
  output logic             ctrl_sda_o,
  output logic             scl_rise_o,
  output logic             scl_fall_o,
  output logic             start_det_o,
  output logic             stop_det_o,
  output logic             bus_free_o,
  output logic             arb_lost_o
);

  // Lines are handled as a 2-entry vector: index 0 = SCL, index 1 = SDA.
  logic [1:0]            raw;
  logic [1:0]            synced;
  logic [SyncStages-1:0] sync_q [2];
  logic [FiltW-1:0]      filt_cnt [2];
  logic [1:0]            filt_q;
  logic [1:0]            filt_prev;
  logic [IdleW-1:0]      idle_cnt;

  logic scl_rise_c;
  logic scl_fall_c;
  logic start_c;
  logic stop_c;
  logic both_high;

  assign raw        = {sda_i, scl_i};
  assign synced     = {sync_q[1][SyncStages-1], sync_q[0][SyncStages-1]};
  assign ctrl_scl_o = filt_q[0];
  assign ctrl_sda_o = filt_q[1];

  // Edge conditions on the filtered lines versus their previous-cycle values.
  // A simultaneous SCL change breaks the "SCL high on both cycles" qualifier.
  assign scl_rise_c = filt_q[0] & ~filt_prev[0];
  assign scl_fall_c = ~filt_q[0] & filt_prev[0];
  assign start_c    = filt_prev[0] & filt_q[0] & filt_prev[1] & ~filt_q[1];
  assign stop_c     = filt_prev[0] & filt_q[0] & ~filt_prev[1] & filt_q[1];
  assign both_high  = filt_q[0] & filt_q[1];

  // Synchronise each pad, then accept a new level only after it has held for filt_cycles_i+1 samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i]   <= '1;
        filt_cnt[i] <= '0;
      end
      filt_q <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync_q[i] <= {sync_q[i][SyncStages-2:0], raw[i]};
        if (synced[i] == filt_q[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] >= filt_cycles_i) begin
          // >= rather than == keeps the counter bounded if the threshold is lowered mid-count.
          filt_q[i]   <= synced[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Register edge, START/STOP and arbitration-loss pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_prev   <= 2'b11;
      scl_rise_o  <= 1'b0;
      scl_fall_o  <= 1'b0;
      start_det_o <= 1'b0;
      stop_det_o  <= 1'b0;
      arb_lost_o  <= 1'b0;
    end else begin
      filt_prev   <= filt_q;
      scl_rise_o  <= scl_rise_c;
      scl_fall_o  <= scl_fall_c;
      start_det_o <= start_c;
      stop_det_o  <= stop_c;
      // We released SDA (open-drain, not driving low) yet someone else holds it low at SCL rise.
      arb_lost_o  <= scl_rise_c & ~sda_pp_en_i & ~sda_en_o & ~filt_q[1];
    end
  end

  // Count cycles with both lines high (saturating) and flag bus-free once past threshold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt   <= '0;
      bus_free_o <= 1'b0;
    end else begin
      if (both_high) begin
        if (idle_cnt != '1) begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
      bus_free_o <= both_high && (idle_cnt >= idle_cycles_i);
    end
  end

  // Pad drive: open-drain pulls low via enable only, push-pull drives the level with enable held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_o    <= 1'b0;
      scl_en_o <= 1'b0;
      sda_o    <= 1'b0;
      sda_en_o <= 1'b0;
    end else begin
      scl_o    <= scl_pp_en_i & ctrl_scl_i;
      scl_en_o <= scl_pp_en_i | ~ctrl_scl_i;
      sda_o    <= sda_pp_en_i & ctrl_sda_i;
      sda_en_o <= sda_pp_en_i | ~ctrl_sda_i;
    end
  end

endmodule
